instr_encoder: RTL
==================

// Module: instr_encoder
// PURPOSE
//  Encoding counterpart of the immediate decoder. Accepts decoded instruction fields (format, opcode, regs,
//  funct, 32-bit signed imm) over a valid/ready stream and packs them into 32-bit RV32I words. Emits each word
//  with an auto-incrementing word address toward instruction-memory load logic. Used by the program
//  loader / self-test path.
// PARAMETERS
//  ADDR_W     10  width of output word address; counter wraps modulo 2^ADDR_W
//  BASE_ADDR  0   address of the first word after start
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       synchronous, active-high reset
//  start      in   1       1-cycle pulse: clear addr/err, enter RUN
//  in_valid   in   1       field bundle valid
//  in_ready   out  1       bundle accepted when in_valid&&in_ready
//  in_fmt     in   3       0=R 1=I 2=S 3=B 4=U 5=J; 6,7 illegal
//  in_opcode  in   7       opcode[6:0]
//  in_rd      in   5       rd
//  in_rs1     in   5       rs1
//  in_rs2     in   5       rs2
//  in_funct3  in   3       funct3
//  in_funct7  in   7       funct7 (R only)
//  in_imm     in   32      signed byte-offset / full U value
//  in_last    in   1       marks final bundle of the program
//  out_valid  out  1       encoded word valid
//  out_ready  in   1       sink accepts when out_valid&&out_ready
//  out_instr  out  32      encoded instruction
//  out_addr   out  ADDR_W  word address of out_instr
//  out_err    out  1       per-word error flag, qualified by out_valid
//  err        out  1       sticky error, cleared by start or rst
//  done       out  1       1-cycle pulse on handshake of the last word
// BEHAVIOUR
//  Reset: FSM=IDLE; in_ready=0, out_valid=0, out_instr=0, out_addr=BASE_ADDR, out_err=0, err=0, done=0.
//  FSM: IDLE -start-> RUN; RUN -accept with in_last-> DRAIN; DRAIN -out handshake-> IDLE, done=1 that cycle.
//  start in RUN/DRAIN: pending output dropped (out_valid=0), addr=BASE_ADDR, err=0, stay/enter RUN.
//  start has priority over a same-cycle input accept; that bundle is not accepted.
//  in_ready = (state==RUN) && (!out_valid || out_ready). Single output register, latency 1 cycle.
//   Full-throughput under out_ready=1. out_* hold stable while out_valid&&!out_ready.
//  Addr: first word after start at BASE_ADDR; +1 after each output handshake; wraps 2^ADDR_W-1 -> 0.
//  Packing: R {f7,rs2,rs1,f3,rd,op}; I {imm[11:0],rs1,f3,rd,op}; S {imm[11:5],rs2,rs1,f3,imm[4:0],op};
//   B {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}; U {imm[31:12],rd,op};
//   J {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}. Unused imm bits ignored.
//  Illegal fmt: emit NOP 32'h0000_0013, out_err=1, err set.
//  Bundles offered in IDLE are ignored (in_ready=0).
// CONFIGURATION
//  RANGE_CHECK_EN defined: I/S imm must equal sext(imm[11:0]); B sext(imm[12:0]) with imm[0]=0;
//   J sext(imm[20:0]) with imm[0]=0; U imm[11:0]=0. Violation -> word still emitted (truncated), out_err=1, err set.
//  Undefined: no range checks; out_err/err only for illegal fmt.
// STRUCTURE
//  riscv_pkg: FMT_R..FMT_J constants, opcode constants (OP_IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR),
//   NOP_INSTR, FSM state encodings.
//  Sub-module instr_field_pack: combinational fields->word plus range-error flag. FSM, handshake, addr counter in top.
// TESTING
//  start; I op=0x13 rd=1 rs1=0 f3=0 imm=5 -> out_instr=0x00500093 addr=0.
//  S op=0x23 rs1=1 rs2=2 f3=2 imm=8 -> 0x0020A423; B op=0x63 rs1=1 rs2=2 f3=0 imm=8 -> 0x00208463.
//  J op=0x6F rd=0 imm=-4 -> 0xFFDFF06F; U op=0x37 rd=5 imm=0x12345000 with in_last -> 0x123452B7, done pulse, FSM IDLE.
//  out_ready=0 for 3 cycles mid-stream -> in_ready=0, out_* stable, no word lost/duplicated, addrs contiguous.
//  ADDR_W=2: 5 words -> addrs 0,1,2,3,0; fmt=6 -> 0x00000013 with out_err=1, err sticky until start.
//  RANGE_CHECK_EN: I imm=4096 -> out_err=1, err=1; B imm=6 -> ok; B imm=7 -> out_err=1. Without macro -> out_err=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants: instruction formats, base opcodes, the canonical NOP
// and the encoder FSM states.
package riscv_pkg;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;

    // addi x0, x0, 0 -- emitted in place of any bundle with an illegal format
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } enc_state_t;

endpackage

// File: rtl/instr_field_pack.sv
// Combinational packer: decoded fields -> 32-bit RV32I word plus an error flag.
// Defining RANGE_CHECK_EN additionally flags immediates that do not fit their format.
module instr_field_pack
    import riscv_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        err
);

    logic fmt_err;
    logic range_err;

    always_comb begin
        instr   = NOP_INSTR;
        fmt_err = 1'b0;
        case (fmt)
            FMT_R:   instr = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I:   instr = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S:   instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B:   instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            FMT_U:   instr = {imm[31:12], rd, opcode};
            FMT_J:   instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: fmt_err = 1'b1;
        endcase
    end

`ifdef RANGE_CHECK_EN
    // An immediate fits when sign-extending its encodable low bits reproduces it exactly
    always_comb begin
        range_err = 1'b0;
        case (fmt)
            FMT_I, FMT_S: range_err = (imm != {{20{imm[11]}}, imm[11:0]});
            FMT_B:        range_err = (imm != {{19{imm[12]}}, imm[12:0]}) || imm[0];
            FMT_U:        range_err = (imm[11:0] != 12'd0);
            FMT_J:        range_err = (imm != {{11{imm[20]}}, imm[20:0]}) || imm[0];
            default:      range_err = 1'b0;
        endcase
    end
`else
    assign range_err = 1'b0;
`endif

    assign err = fmt_err || range_err;

endmodule

// File: rtl/instr_encoder.sv
// Streams decoded instruction bundles into RV32I words with auto-incrementing word addresses.
// Optional immediate range checking is enabled by RANGE_CHECK_EN (see instr_field_pack).
module instr_encoder
    import riscv_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic              err,
    output logic              done
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    enc_state_t        state;
    logic [ADDR_W-1:0] addr_cnt;
    logic [31:0]       pack_instr;
    logic              pack_err;
    logic              accept;

    instr_field_pack u_pack (
        .fmt    (in_fmt),
        .opcode (in_opcode),
        .rd     (in_rd),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .funct3 (in_funct3),
        .funct7 (in_funct7),
        .imm    (in_imm),
        .instr  (pack_instr),
        .err    (pack_err)
    );

    // Single output register: accept a new bundle whenever it is empty or draining this cycle
    assign in_ready = (state == ST_RUN) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // addr_cnt is the address the next accepted word will carry; wraps naturally at 2^ADDR_W
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_instr <= 32'd0;
            out_addr  <= BASE;
            out_err   <= 1'b0;
            err       <= 1'b0;
            done      <= 1'b0;
            addr_cnt  <= BASE;
        end else begin
            done <= 1'b0;
            if (start) begin
                state     <= ST_RUN;
                out_valid <= 1'b0;
                out_err   <= 1'b0;
                err       <= 1'b0;
                out_addr  <= BASE;
                addr_cnt  <= BASE;
            end else begin
                if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                    if (state == ST_DRAIN) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                end
                if (accept) begin
                    out_valid <= 1'b1;
                    out_instr <= pack_instr;
                    out_err   <= pack_err;
                    out_addr  <= addr_cnt;
                    addr_cnt  <= addr_cnt + 1'b1;
                    if (pack_err) err <= 1'b1;
                    if (in_last) state <= ST_DRAIN;
                end
            end
        end
    end

endmodule
